// File: rtl/cpu_pkg.sv
// Shared LEGv8 datapath parameters: widths, control-bundle bit positions and ALUOp codes.
// Used by the control unit, the pipeline registers and the execute stage.
package cpu_pkg;

  localparam int BITSIZE = 64;
  localparam int REGSIZE = 32;
  localparam int RW      = $clog2(REGSIZE);
  localparam int CTRLW   = 9;

  // Control bundle layout: {RegWrite, MemRead, MemWrite, ALUSrc, MemtoReg, Branch, Uncond, ALUOp[1:0]}
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_UNCOND   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  localparam logic [1:0] ALUOP_LDST  = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic {
    ST_LOAD   = 1'b0,
    ST_BUBBLE = 1'b1
  } id_ex_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in execute whose destination feeds the instruction in decode.
// Purely combinational so any pipeline register in front of it can share the equation.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_rd,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rn,
  input  logic [RW-1:0] id_rm,
  output logic          hazard
);

  // Both sources are compared regardless of format; a false stall only costs a cycle.
  always_comb begin
    hazard = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
             ((ex_rd == id_rn) || (ex_rd == id_rm));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle writeback bypass, load-use stall/bubble and flush.
// Bubbles and invalid slots always carry an all-zero control bundle.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [RW-1:0]      id_rn,
  input  logic [RW-1:0]      id_rm,
  input  logic [RW-1:0]      id_rd,
  input  logic [BITSIZE-1:0] id_data1,
  input  logic [BITSIZE-1:0] id_data2,
  input  logic [BITSIZE-1:0] id_imm,
  input  logic [CTRLW-1:0]   id_ctrl,
  input  logic               wb_en,
  input  logic [RW-1:0]      wb_sel,
  input  logic [BITSIZE-1:0] wb_data,
  input  logic               flush,
  output logic               stall,
  output logic               ex_valid,
  output logic [BITSIZE-1:0] ex_data1,
  output logic [BITSIZE-1:0] ex_data2,
  output logic [BITSIZE-1:0] ex_imm,
  output logic [RW-1:0]      ex_rn,
  output logic [RW-1:0]      ex_rm,
  output logic [RW-1:0]      ex_rd,
  output logic [CTRLW-1:0]   ex_ctrl
);

  id_ex_state_t       state_q, state_d;
  logic               hazard;
  logic [BITSIZE-1:0] op_a, op_b;

  hazard_detect u_hazard_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[CTRL_MEMREAD]),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .hazard      (hazard)
  );

  // A bubble clears MemRead, so BUBBLE can never be followed by a second stall.
  always_comb begin
    state_d = ST_LOAD;
    stall   = 1'b0;
    if (state_q == ST_LOAD && hazard) begin
      stall   = 1'b1;
      state_d = ST_BUBBLE;
    end
    if (flush) begin
      state_d = ST_LOAD;
    end
  end

  // X0 is hard-wired zero and never written, so it is excluded from bypass.
  always_comb begin
    op_a = id_data1;
    op_b = id_data2;
    if (wb_en && (wb_sel != '0) && (wb_sel == id_rn)) begin
      op_a = wb_data;
    end
    if (wb_en && (wb_sel != '0) && (wb_sel == id_rm)) begin
      op_b = wb_data;
    end
  end

  // On flush or stall only valid/control are cleared; data fields hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LOAD;
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_data1 <= '0;
      ex_data2 <= '0;
      ex_imm   <= '0;
      ex_rn    <= '0;
      ex_rm    <= '0;
      ex_rd    <= '0;
    end else begin
      state_q <= state_d;
      if (flush || stall) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end else begin
        ex_valid <= id_valid;
        ex_ctrl  <= id_valid ? id_ctrl : '0;
        ex_data1 <= op_a;
        ex_data2 <= op_b;
        ex_imm   <= id_imm;
        ex_rn    <= id_rn;
        ex_rm    <= id_rm;
        ex_rd    <= id_rd;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, flow, bypass, load-use, flush and reset-in-stall.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               id_valid;
  logic [RW-1:0]      id_rn, id_rm, id_rd;
  logic [BITSIZE-1:0] id_data1, id_data2, id_imm;
  logic [CTRLW-1:0]   id_ctrl;
  logic               wb_en;
  logic [RW-1:0]      wb_sel;
  logic [BITSIZE-1:0] wb_data;
  logic               flush;
  logic               stall;
  logic               ex_valid;
  logic [BITSIZE-1:0] ex_data1, ex_data2, ex_imm;
  logic [RW-1:0]      ex_rn, ex_rm, ex_rd;
  logic [CTRLW-1:0]   ex_ctrl;

  int checks = 0;
  int errors = 0;

  // ADD: RegWrite, ALUOp=10.  LDUR: RegWrite, MemRead, ALUSrc, MemtoReg, ALUOp=00.
  localparam logic [CTRLW-1:0] CTRL_ADD  = 9'h102;
  localparam logic [CTRLW-1:0] CTRL_LDUR = 9'h1B0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
    .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [RW-1:0] rn, input logic [RW-1:0] rm,
                       input logic [RW-1:0] rd, input logic [BITSIZE-1:0] d1,
                       input logic [BITSIZE-1:0] d2, input logic [CTRLW-1:0] c);
    id_valid = v; id_rn = rn; id_rm = rm; id_rd = rd;
    id_data1 = d1; id_data2 = d2; id_imm = 64'h0; id_ctrl = c;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    id_valid = 1'b1; id_rn = RW'($urandom()); id_rm = RW'($urandom()); id_rd = RW'($urandom());
    id_data1 = {$urandom(), $urandom()}; id_data2 = {$urandom(), $urandom()};
    id_imm = {$urandom(), $urandom()}; id_ctrl = CTRL_LDUR;
    wb_en = 1'b1; wb_sel = RW'($urandom()); wb_data = {$urandom(), $urandom()};
    tick(); tick();
    checks++;
    if ({ex_valid, ex_ctrl, ex_rn, ex_rm, ex_rd} !== '0 ||
        {ex_data1, ex_data2, ex_imm} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs valid=%0b ctrl=%h d1=%h d2=%h imm=%h rn=%0d rm=%0d rd=%0d required all 0",
               ex_valid, ex_ctrl, ex_data1, ex_data2, ex_imm, ex_rn, ex_rm, ex_rd);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_stall got=%0b required=0", stall);
    end
    rst = 1'b0; wb_en = 1'b0; wb_sel = '0; wb_data = '0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 9'h0);
    tick();
  endtask

  task automatic test_plain_flow();
    drive(1'b1, 5'd1, 5'd2, 5'd4, 64'd5, 64'd7, CTRL_ADD);
    tick();
    checks++;
    if ({ex_valid, ex_data1, ex_data2} !== {1'b1, 64'd5, 64'd7}) begin
      errors++;
      $display("[TB] FAIL plain_data valid=%0b d1=%0d d2=%0d required 1/5/7", ex_valid, ex_data1, ex_data2);
    end
    checks++;
    if ({ex_rn, ex_rm, ex_rd, ex_ctrl} !== {5'd1, 5'd2, 5'd4, CTRL_ADD}) begin
      errors++;
      $display("[TB] FAIL plain_ctrl rn=%0d rm=%0d rd=%0d ctrl=%h required 1/2/4/%h", ex_rn, ex_rm, ex_rd, ex_ctrl, CTRL_ADD);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("[TB] FAIL plain_stall got=%0b required=0", stall);
    end
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_sel = 5'd3; wb_data = 64'h55;
    drive(1'b1, 5'd3, 5'd5, 5'd6, 64'hAA, 64'h11, CTRL_ADD);
    tick();
    checks++;
    if ({ex_data1, ex_data2} !== {64'h55, 64'h11}) begin
      errors++; $display("[TB] FAIL bypass_a d1=%h d2=%h required 55/11", ex_data1, ex_data2);
    end
    wb_sel = 5'd5;
    tick();
    checks++;
    if ({ex_data1, ex_data2} !== {64'hAA, 64'h55}) begin
      errors++; $display("[TB] FAIL bypass_b d1=%h d2=%h required aa/55", ex_data1, ex_data2);
    end
    wb_sel = 5'd0;
    drive(1'b1, 5'd0, 5'd0, 5'd6, 64'hAA, 64'hBB, CTRL_ADD);
    tick();
    checks++;
    if ({ex_data1, ex_data2} !== {64'hAA, 64'hBB}) begin
      errors++; $display("[TB] FAIL bypass_x0 d1=%h d2=%h required aa/bb", ex_data1, ex_data2);
    end
    wb_en = 1'b0; wb_sel = 5'd3;
    drive(1'b1, 5'd3, 5'd5, 5'd6, 64'hAA, 64'h11, CTRL_ADD);
    tick();
    checks++;
    if (ex_data1 !== 64'hAA) begin
      errors++; $display("[TB] FAIL bypass_disabled d1=%h required aa", ex_data1);
    end
    wb_sel = '0; wb_data = '0;
  endtask

  task automatic test_invalid_slot();
    drive(1'b0, 5'd7, 5'd8, 5'd9, 64'h123, 64'h456, CTRL_LDUR);
    tick();
    checks++;
    if ({ex_valid, ex_ctrl, ex_data1} !== {1'b0, 9'h0, 64'h123}) begin
      errors++; $display("[TB] FAIL invalid_slot valid=%0b ctrl=%h d1=%h required 0/000/123", ex_valid, ex_ctrl, ex_data1);
    end
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd1, 5'd0, 5'd9, 64'h10, 64'h0, CTRL_LDUR);
    tick();
    checks++;
    if ({ex_valid, ex_ctrl, ex_rd} !== {1'b1, CTRL_LDUR, 5'd9}) begin
      errors++; $display("[TB] FAIL load_in_stage valid=%0b ctrl=%h rd=%0d required 1/%h/9", ex_valid, ex_ctrl, ex_rd, CTRL_LDUR);
    end
    drive(1'b1, 5'd2, 5'd9, 5'd10, 64'h20, 64'h30, CTRL_ADD);
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("[TB] FAIL load_use_stall got=%0b required=1", stall);
    end
    tick();
    checks++;
    if ({ex_valid, ex_ctrl, stall} !== {1'b0, 9'h0, 1'b0}) begin
      errors++; $display("[TB] FAIL bubble valid=%0b ctrl=%h stall=%0b required 0/000/0", ex_valid, ex_ctrl, stall);
    end
    tick();
    checks++;
    if ({ex_valid, ex_rm, ex_ctrl, stall} !== {1'b1, 5'd9, CTRL_ADD, 1'b0}) begin
      errors++; $display("[TB] FAIL after_bubble valid=%0b rm=%0d ctrl=%h stall=%0b required 1/9/%h/0", ex_valid, ex_rm, ex_ctrl, stall, CTRL_ADD);
    end
    drive(1'b1, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, CTRL_LDUR);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd11, 64'h0, 64'h0, CTRL_ADD);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("[TB] FAIL load_x0_no_stall got=%0b required=0", stall);
    end
    drive(1'b1, 5'd1, 5'd0, 5'd12, 64'h0, 64'h0, CTRL_LDUR);
    tick();
    drive(1'b1, 5'd12, 5'd3, 5'd13, 64'h0, 64'h0, CTRL_ADD);
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("[TB] FAIL load_use_rn_stall got=%0b required=1", stall);
    end
    tick();
    tick();
  endtask

  task automatic test_flush_priority();
    drive(1'b1, 5'd1, 5'd0, 5'd9, 64'h0, 64'h0, CTRL_LDUR);
    tick();
    drive(1'b1, 5'd9, 5'd2, 5'd10, 64'h40, 64'h50, CTRL_ADD);
    flush = 1'b1;
    tick();
    checks++;
    if ({ex_valid, ex_ctrl} !== {1'b0, 9'h0}) begin
      errors++; $display("[TB] FAIL flush_with_stall valid=%0b ctrl=%h required 0/000", ex_valid, ex_ctrl);
    end
    flush = 1'b0;
    drive(1'b1, 5'd4, 5'd5, 5'd6, 64'h60, 64'h70, CTRL_ADD);
    tick();
    checks++;
    if ({ex_valid, ex_ctrl, ex_data1} !== {1'b1, CTRL_ADD, 64'h60}) begin
      errors++; $display("[TB] FAIL after_flush valid=%0b ctrl=%h d1=%h required 1/%h/60", ex_valid, ex_ctrl, ex_data1, CTRL_ADD);
    end
    flush = 1'b1;
    drive(1'b1, 5'd7, 5'd8, 5'd9, 64'h80, 64'h90, CTRL_ADD);
    tick();
    checks++;
    if ({ex_valid, ex_ctrl} !== {1'b0, 9'h0}) begin
      errors++; $display("[TB] FAIL flush_only valid=%0b ctrl=%h required 0/000", ex_valid, ex_ctrl);
    end
    flush = 1'b0;
  endtask

  task automatic test_stall_with_bypass();
    drive(1'b1, 5'd1, 5'd0, 5'd9, 64'h0, 64'h0, CTRL_LDUR);
    tick();
    wb_en = 1'b1; wb_sel = 5'd3; wb_data = 64'h77;
    drive(1'b1, 5'd9, 5'd3, 5'd14, 64'h0, 64'h33, CTRL_ADD);
    tick();
    wb_en = 1'b0; wb_sel = '0; wb_data = '0;
    drive(1'b1, 5'd9, 5'd3, 5'd14, 64'h99, 64'h77, CTRL_ADD);
    tick();
    checks++;
    if ({ex_valid, ex_data1, ex_data2} !== {1'b1, 64'h99, 64'h77}) begin
      errors++; $display("[TB] FAIL stall_bypass valid=%0b d1=%h d2=%h required 1/99/77", ex_valid, ex_data1, ex_data2);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd1, 5'd0, 5'd9, 64'h0, 64'h0, CTRL_LDUR);
    tick();
    drive(1'b1, 5'd2, 5'd9, 5'd10, 64'h5, 64'h6, CTRL_ADD);
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("[TB] FAIL pre_reset_stall got=%0b required=1", stall);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({ex_valid, ex_ctrl, ex_rd, ex_data1, stall} !== '0) begin
      errors++; $display("[TB] FAIL reset_mid_stall valid=%0b ctrl=%h rd=%0d d1=%h stall=%0b required all 0",
                         ex_valid, ex_ctrl, ex_rd, ex_data1, stall);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_plain_flow();
    test_bypass();
    test_invalid_slot();
    test_load_use();
    test_flush_priority();
    test_stall_with_bypass();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode/operand-read and execute in the 64-bit LEGv8 datapath. Captures the two register-file read values, immediate, destination index and control bundle once per cycle, and bypasses a same-cycle writeback so execute never sees a stale operand. Detects load-use hazards, stalls fetch/decode for one cycle, injects a bubble, and squashes its contents on a branch flush.

## Interface
- BITSIZE, 64, datapath width
- REGSIZE, 32, architectural register count; index width RW = $clog2(REGSIZE)
- CTRLW, 9, control bundle width: {RegWrite, MemRead, MemWrite, ALUSrc, MemtoReg, Branch, Uncond, ALUOp[1:0]}

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode holds a real instruction
- id_rn, id_rm, id_rd  in  RW each  source/destination indices
- id_data1, id_data2  in  BITSIZE each  register-file read data for rn/rm
- id_imm  in  BITSIZE  sign-extended immediate
- id_ctrl  in  CTRLW  decoded control
- wb_en  in  1  writeback enable (same signal driving the register file)
- wb_sel  in  RW  writeback index
- wb_data  in  BITSIZE  writeback data
- flush  in  1  branch taken; squash this stage
- stall  out  1  combinational; freeze PC and IF/ID this cycle
- ex_valid  out  1  execute holds a real instruction
- ex_data1, ex_data2, ex_imm  out  BITSIZE each
- ex_rn, ex_rm, ex_rd  out  RW each
- ex_ctrl  out  CTRLW

## Operation
- Bypass: operand A = wb_data when wb_en && wb_sel==id_rn && wb_sel!=0, else id_data1. Same rule for B with id_rm. Register 0 is never written, so it is never bypassed.
- Load-use: stall = ex_valid && ex_ctrl.MemRead && ex_rd!=0 && id_valid && (ex_rd==id_rn || ex_rd==id_rm). Both sources are compared irrespective of instruction format.
- Per-edge update priority:
  - rst: every output register cleared to 0.
  - flush: ex_valid←0, ex_ctrl←0. Data fields are don't-care and hold. flush overrides stall.
  - stall: bubble, i.e. ex_valid←0, ex_ctrl←0. Decode is frozen upstream and re-presents the same instruction next cycle.
  - otherwise: load all fields; ex_valid←id_valid; ex_ctrl←id_valid ? id_ctrl : 0.
- A bubble or invalid slot always carries ex_ctrl=0, so no RegWrite or MemWrite leaks downstream.
- Two-state control: LOAD and BUBBLE. BUBBLE lasts exactly one cycle because the bubble clears MemRead. Back-to-back stalls for one instruction are impossible.

## Timing
- Latency 1 cycle, decode inputs to ex_* outputs.
- stall is combinational from registered ex_* and from id_* inputs, valid in the same cycle. No path from wb_* to stall.
- Bypass path wb_* → ex_data* is combinational into the register D input only.
- Reset values: ex_valid=0, ex_ctrl=0, all data and index outputs 0. stall is 0 during and after reset until a load sits in the stage.
- rst asserted mid-stall or mid-flush: stage is empty next cycle, stall falls to 0.
- Simultaneous stall and wb bypass: the held instruction re-samples next cycle, and the write is then visible from the register file itself.

## Structure
- Shared package (cpu_pkg): BITSIZE, REGSIZE, RW, CTRLW, and named bit positions/localparams for every control bit plus ALUOp encodings. The control unit and later stages use the same package.
- One natural sub-module, hazard_detect: pure combinational stall equation, reusable by an IF/ID register.
- Bypass muxes and the pipeline register stay inline.

## Test plan
- Reset: rst=1 for 2 cycles with random inputs → all ex_* =0, stall=0.
- Plain flow: ADD id_rn=1, id_rm=2, data1=5, data2=7, ctrl RegWrite=1 → next cycle ex_valid=1, ex_data1=5, ex_data2=7, ctrl passed through.
- Bypass: id_rn=3, id_data1=0xAA, wb_en=1, wb_sel=3, wb_data=0x55 → ex_data1=0x55. Repeat with wb_sel=0, id_rn=0 → ex_data1=id_data1.
- Load-use: LDUR into X9 in stage, then ADD with id_rm=9 → stall=1 for one cycle, bubble (ex_valid=0, ex_ctrl=0), then ADD loads with ex_rm=9 and stall=0.
- Flush priority: stall and flush asserted together → ex_valid=0, ex_ctrl=0. Next cycle normal load resumes.
- Reset mid-operation: rst during a stall cycle → outputs 0 next edge, stall=0.
